// File: rtl/vga_timing_if.sv
// Pixel-enable input and raster timing outputs of the VGA timing generator.
// The generator uses the master modport; video-path consumers use the slave modport.
interface vga_timing_if;
  logic       ce;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_cnt;
  logic       hsync_d;
  logic       vsync_d;
  logic       display_on_d;

  modport master (
    input  ce,
    output hpos, vpos, display_on, hsync, vsync, line_start, frame_start,
           frame_cnt, hsync_d, vsync_d, display_on_d
  );

  modport slave (
    output ce,
    input  hpos, vpos, display_on, hsync, vsync, line_start, frame_start,
           frame_cnt, hsync_d, vsync_d, display_on_d
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: pixel coordinates, syncs,
// active-video flag, line/frame strobes, frame counter and delayed sync copies.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned SYNC_DELAY = 0
) (
  input  logic clk,
  input  logic reset,
  vga_timing_if.master vga
);

  localparam int unsigned CW       = 10;
  localparam int unsigned PW       = 11;
  localparam int unsigned FW       = 8;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic          h_last;
  logic          v_last;
  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic [FW-1:0] f_nxt;
  logic          de_nxt;
  logic          hs_act_nxt;
  logic          vs_act_nxt;

  // Next raster position; levels are decoded from it so they register alongside the counters.
  always_comb begin
    h_last     = (vga.hpos == CW'(H_TOTAL - 1));
    v_last     = (vga.vpos == CW'(V_TOTAL - 1));
    h_nxt      = vga.hpos + CW'(1);
    v_nxt      = vga.vpos;
    f_nxt      = vga.frame_cnt;
    if (h_last) begin
      h_nxt = '0;
      if (v_last) begin
        v_nxt = '0;
        f_nxt = vga.frame_cnt + FW'(1);
      end else begin
        v_nxt = vga.vpos + CW'(1);
      end
    end
    de_nxt     = ({1'b0, h_nxt} < PW'(H_ACTIVE)) && ({1'b0, v_nxt} < PW'(V_ACTIVE));
    hs_act_nxt = ({1'b0, h_nxt} >= PW'(HS_START)) && ({1'b0, h_nxt} < PW'(HS_END));
    vs_act_nxt = ({1'b0, v_nxt} >= PW'(VS_START)) && ({1'b0, v_nxt} < PW'(VS_END));
  end

  // Reset parks the raster on its last pixel so the first tick lands on (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      vga.hpos        <= CW'(H_TOTAL - 1);
      vga.vpos        <= CW'(V_TOTAL - 1);
      vga.frame_cnt   <= '1;
      vga.display_on  <= 1'b0;
      vga.hsync       <= ~SYNC_POL;
      vga.vsync       <= ~SYNC_POL;
      vga.line_start  <= 1'b0;
      vga.frame_start <= 1'b0;
    end else begin
      vga.line_start  <= vga.ce && h_last;
      vga.frame_start <= vga.ce && h_last && v_last;
      if (vga.ce) begin
        vga.hpos       <= h_nxt;
        vga.vpos       <= v_nxt;
        vga.frame_cnt  <= f_nxt;
        vga.display_on <= de_nxt;
        vga.hsync      <= hs_act_nxt ? SYNC_POL : ~SYNC_POL;
        vga.vsync      <= vs_act_nxt ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

  // Monitor-facing copies realigned with downstream registered pixel pipelines.
  if (SYNC_DELAY == 0) begin : g_no_delay
    assign vga.hsync_d      = vga.hsync;
    assign vga.vsync_d      = vga.vsync;
    assign vga.display_on_d = vga.display_on;
  end else begin : g_delay
    logic [2:0] stage_q [SYNC_DELAY];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < int'(SYNC_DELAY); i++) begin
          stage_q[i] <= {~SYNC_POL, ~SYNC_POL, 1'b0};
        end
      end else if (vga.ce) begin
        stage_q[0] <= {vga.hsync, vga.vsync, vga.display_on};
        for (int i = 1; i < int'(SYNC_DELAY); i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign {vga.hsync_d, vga.vsync_d, vga.display_on_d} = stage_q[SYNC_DELAY-1];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen: a full-size 640x480 instance and a small
// instance (inverted sync polarity, two delay stages) checked against a raster-index model.
module tb_vga_timing_gen;

  typedef struct packed {
    int unsigned ha, hfp, hs, hbp, va, vfp, vs, vbp, pol, dly;
  } cfg_t;

  localparam cfg_t CFG_A = '{ha: 640, hfp: 16, hs: 96, hbp: 48,
                             va: 480, vfp: 10, vs: 2, vbp: 33, pol: 0, dly: 0};
  localparam cfg_t CFG_B = '{ha: 16, hfp: 4, hs: 6, hbp: 6,
                             va: 10, vfp: 2, vs: 2, vbp: 3, pol: 1, dly: 2};

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Model state: ce ticks since the last reset edge, and whether the last edge was a tick.
  longint ticks    = 0;
  bit     last_tick = 1'b0;

  vga_timing_if vga_a ();
  vga_timing_if vga_b ();

  always #5 clk = ~clk;

  vga_timing_gen u_dut_a (
    .clk   (clk),
    .reset (reset),
    .vga   (vga_a)
  );

  vga_timing_gen #(
    .H_ACTIVE (16), .H_FP (4), .H_SYNC (6), .H_BP (6),
    .V_ACTIVE (10), .V_FP (2), .V_SYNC (2), .V_BP (3),
    .SYNC_POL (1'b1), .SYNC_DELAY (2)
  ) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .vga   (vga_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int unsigned h_tot(cfg_t c);
    return c.ha + c.hfp + c.hs + c.hbp;
  endfunction

  function automatic int unsigned n_pix(cfg_t c);
    return h_tot(c) * (c.va + c.vfp + c.vs + c.vbp);
  endfunction

  // Linear raster index after n ticks: reset sits on the final pixel of the frame.
  function automatic longint lin_of(cfg_t c, longint n);
    return (longint'(n_pix(c)) - 1 + n) % longint'(n_pix(c));
  endfunction

  // {hsync, vsync, display_on} for a raster index, straight from the porch layout.
  function automatic logic [2:0] levels(cfg_t c, longint lin);
    longint h, v;
    logic   act;
    logic   hs, vs, de;
    act = (c.pol != 0);
    h  = lin % longint'(h_tot(c));
    v  = lin / longint'(h_tot(c));
    hs = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs) ? act : ~act;
    vs = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vs) ? act : ~act;
    de = (h < c.ha) && (v < c.va);
    return {hs, vs, de};
  endfunction

  task automatic check_dut(input string name, input cfg_t c,
                           input logic [9:0] hpos, input logic [9:0] vpos,
                           input logic [7:0] fcnt, input logic [7:0] flags);
    longint     lin;
    logic [2:0] now_lv, dly_lv;
    logic       ls, fs, act;
    logic [7:0] exp_flags;
    act    = (c.pol != 0);
    lin    = lin_of(c, ticks);
    now_lv = levels(c, lin);
    dly_lv = (ticks < longint'(c.dly)) ? {~act, ~act, 1'b0}
                                       : levels(c, lin_of(c, ticks - longint'(c.dly)));
    ls = last_tick && (lin % longint'(h_tot(c)) == 0);
    fs = last_tick && (lin == 0);
    exp_flags = {now_lv, ls, fs, dly_lv};
    check({name, ".hpos"},  32'(hpos), 32'(lin % longint'(h_tot(c))));
    check({name, ".vpos"},  32'(vpos), 32'(lin / longint'(h_tot(c))));
    check({name, ".fcnt"},  32'(fcnt),
          32'((255 + (longint'(n_pix(c)) - 1 + ticks) / longint'(n_pix(c))) % 256));
    check({name, ".flags"}, 32'(flags), 32'(exp_flags));
  endtask

  // One clock: drive inputs, advance the model at the edge, sample on the falling edge.
  task automatic step(input logic r, input logic c);
    reset    = r;
    vga_a.ce = c;
    vga_b.ce = c;
    @(posedge clk);
    cyc++;
    if (r) begin
      ticks     = 0;
      last_tick = 1'b0;
    end else begin
      last_tick = c;
      if (c) ticks++;
    end
    @(negedge clk);
    check_dut("a", CFG_A, vga_a.hpos, vga_a.vpos, vga_a.frame_cnt,
              {vga_a.hsync, vga_a.vsync, vga_a.display_on, vga_a.line_start,
               vga_a.frame_start, vga_a.hsync_d, vga_a.vsync_d, vga_a.display_on_d});
    check_dut("b", CFG_B, vga_b.hpos, vga_b.vpos, vga_b.frame_cnt,
              {vga_b.hsync, vga_b.vsync, vga_b.display_on, vga_b.line_start,
               vga_b.frame_start, vga_b.hsync_d, vga_b.vsync_d, vga_b.display_on_d});
  endtask

  initial begin
    reset    = 1'b1;
    vga_a.ce = 1'b1;
    vga_b.ce = 1'b1;
    @(negedge clk);
    repeat (3) step(1'b1, 1'b1);
    // Free run past the first line wrap of the full-size raster.
    repeat (1700) step(1'b0, 1'b1);
    // Mid-frame reset with ce held high, then restart.
    step(1'b1, 1'b1);
    repeat (300) step(1'b0, 1'b1);
    // ce pattern 1,0,0,1.
    for (int k = 0; k < 400; k++) step(1'b0, (k % 4 == 0) || (k % 4 == 3));
    // Random ce with occasional resets, including reset during ce=0.
    for (int k = 0; k < 4000; k++) begin
      step(($urandom_range(0, 599) == 0), ($urandom_range(0, 3) != 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
